riscv_core_icache_axi_refill: RTL

//  I-cache line-refill engine; sits directly downstream of the I-cache controller.
//  - Takes one miss request (addr + req level); issues one AXI4 read burst.
//  - Packs the returned beats into a LINE_WIDTH line.
//  - Pulses done so the controller can write the line and update tag/valid.
//  - One outstanding transaction only. Read-only: no AW/W/B channels.

---
 rtl/riscv_core_icache_axi_refill.sv | 137 +++++++++++++
 1 files changed

// File: rtl/riscv_core_icache_axi_refill.sv
// I-cache line-refill engine: issues one AXI4 read burst per miss and packs the beats into a line.
// Optional feature macro ICACHE_REFILL_CWF_EN: critical-word-first WRAP burst, line still in natural order.
module riscv_core_icache_axi_refill #(
   parameter int ADDR_WIDTH     = 32,
   parameter int LINE_WIDTH     = 256,
   parameter int AXI_DATA_WIDTH = 64,
   parameter int AXI_ID_WIDTH   = 4,
   parameter int AXI_ID         = 0
) (
   input  logic                      i_clk,
   input  logic                      i_rst_n,
   input  logic                      i_mem_req,
   input  logic [ADDR_WIDTH-1:0]     i_addr,
   output logic                      o_mem_done,
   output logic [LINE_WIDTH-1:0]     o_line_data,
   output logic                      o_bus_err,
   output logic                      o_arvalid,
   input  logic                      i_arready,
   output logic [ADDR_WIDTH-1:0]     o_araddr,
   output logic [7:0]                o_arlen,
   output logic [2:0]                o_arsize,
   output logic [1:0]                o_arburst,
   output logic [AXI_ID_WIDTH-1:0]   o_arid,
   output logic [3:0]                o_arcache,
   output logic [2:0]                o_arprot,
   input  logic                      i_rvalid,
   output logic                      o_rready,
   input  logic [AXI_DATA_WIDTH-1:0] i_rdata,
   input  logic [1:0]                i_rresp,
   input  logic                      i_rlast
);

   localparam int BEATS      = LINE_WIDTH / AXI_DATA_WIDTH;
   localparam int CNT_W      = $clog2(BEATS);
   localparam int BEAT_BYTES = AXI_DATA_WIDTH / 8;
   localparam int BEAT_SHIFT = $clog2(BEAT_BYTES);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

   typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;

   state_t                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   addr_q, req_addr;
   logic [CNT_W-1:0]        cnt_q, start_q, req_start, slot;
   logic                    err_q, beat_err, last_beat;
   logic [LINE_WIDTH-1:0]   line_q;

`ifdef ICACHE_REFILL_CWF_EN
   // The wrap burst starts at the missing beat; its line offset tells where beat 0 lands.
   assign req_addr  = i_addr & ~ADDR_WIDTH'(BEAT_BYTES - 1);
   assign req_start = i_addr[BEAT_SHIFT +: CNT_W];
   assign o_arburst = 2'b10;
`else
   localparam int LINE_BYTES = LINE_WIDTH / 8;
   assign req_addr  = i_addr & ~ADDR_WIDTH'(LINE_BYTES - 1);
   assign req_start = '0;
   assign o_arburst = 2'b01;
`endif

   assign o_arlen     = 8'(BEATS - 1);
   assign o_arsize    = 3'(BEAT_SHIFT);
   assign o_arid      = AXI_ID_WIDTH'(AXI_ID);
   assign o_arcache   = 4'b0010;
   assign o_arprot    = 3'b100;
   assign o_araddr    = addr_q;
   assign o_line_data = line_q;

   assign slot      = start_q + cnt_q;
   assign last_beat = (cnt_q == LAST_CNT);
   // The count, not rlast, ends the burst; a misplaced rlast only flags an error.
   assign beat_err  = ((i_rresp & 2'b10) != 2'b00) || (i_rlast != last_beat);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      o_arvalid  = 1'b0;
      o_rready   = 1'b0;
      o_mem_done = 1'b0;
      o_bus_err  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (i_mem_req) state_d = ADDR;
         end
         ADDR: begin
            o_arvalid = 1'b1;
            if (i_arready) state_d = DATA;
         end
         DATA: begin
            o_rready = 1'b1;
            if (i_rvalid && last_beat) state_d = DONE;
         end
         DONE: begin
            o_mem_done = 1'b1;
            o_bus_err  = err_q;
            state_d    = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         addr_q  <= '0;
         start_q <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
         line_q  <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (i_mem_req) begin
                  addr_q  <= req_addr;
                  start_q <= req_start;
                  cnt_q   <= '0;
                  err_q   <= 1'b0;
               end
            end
            DATA: begin
               if (i_rvalid) begin
                  line_q[slot*AXI_DATA_WIDTH +: AXI_DATA_WIDTH] <= i_rdata;
                  cnt_q <= cnt_q + 1'b1;
                  err_q <= err_q | beat_err;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule
